// File: rtl/mdl_bytecntr_nch_if.sv
// -----------------------------------------------------------------------------
// mdl_bytecntr_nch_if
// Groups the control inputs and status outputs of the multi-channel bubble
// byte counter into one bundle.
//
//   master modport : drives the control inputs, observes the status outputs
//   slave modport  : the counter block itself
//
// Signals (CH = number of channels):
//   i_CLK2M_PCEN_n  1   active-low clock enable
//   i_ROT20_n       20  active-low one-hot rotation phase
//   i_4BEN_n        1   active-low 4-bubble mode (extra sample phases)
//   i_CH_EN         CH  per-channel enable
//   i_GLCNT_RD      CH  per-channel bit-read strobe
//   i_NEWBYTE       1   bit-counter reload, all channels
//   i_ACC_ACT_n     1   high = access inactive, clears bit and byte counters
//   i_BUBWR_WAIT    1   forces DONE high at the next sample
//   o_BYTEACQ_DONE  CH  per-channel byte-acquired flag
//   o_PAGE_DONE     CH  per-channel page-full flag
//   o_ALL_DONE      1   every enabled channel page-full
//   o_OVF           CH  sticky overflow flag (only with BYTECNTR_OVFDET_EN)
//
// Optional feature macro: BYTECNTR_OVFDET_EN
// -----------------------------------------------------------------------------
interface mdl_bytecntr_nch_if #(
  parameter int CH = 2
);
  logic          i_CLK2M_PCEN_n;
  logic [19:0]   i_ROT20_n;
  logic          i_4BEN_n;
  logic [CH-1:0] i_CH_EN;
  logic [CH-1:0] i_GLCNT_RD;
  logic          i_NEWBYTE;
  logic          i_ACC_ACT_n;
  logic          i_BUBWR_WAIT;
  logic [CH-1:0] o_BYTEACQ_DONE;
  logic [CH-1:0] o_PAGE_DONE;
  logic          o_ALL_DONE;
`ifdef BYTECNTR_OVFDET_EN
  logic [CH-1:0] o_OVF;
`endif

  modport master (
    output i_CLK2M_PCEN_n,
    output i_ROT20_n,
    output i_4BEN_n,
    output i_CH_EN,
    output i_GLCNT_RD,
    output i_NEWBYTE,
    output i_ACC_ACT_n,
    output i_BUBWR_WAIT,
    input  o_BYTEACQ_DONE,
    input  o_PAGE_DONE,
`ifdef BYTECNTR_OVFDET_EN
    input  o_OVF,
`endif
    input  o_ALL_DONE
  );

  modport slave (
    input  i_CLK2M_PCEN_n,
    input  i_ROT20_n,
    input  i_4BEN_n,
    input  i_CH_EN,
    input  i_GLCNT_RD,
    input  i_NEWBYTE,
    input  i_ACC_ACT_n,
    input  i_BUBWR_WAIT,
    output o_BYTEACQ_DONE,
    output o_PAGE_DONE,
`ifdef BYTECNTR_OVFDET_EN
    output o_OVF,
`endif
    output o_ALL_DONE
  );
endinterface

// File: rtl/mdl_bytecntr_nch.sv
// -----------------------------------------------------------------------------
// mdl_bytecntr_nch
// Per-channel bit and byte counting for a bubble-memory page transfer.
// Each channel counts bits down from BITS-1 on every read strobe; a read at
// zero completes a byte (wrap) and reloads. Completed bytes are counted up to
// MAXBYTES (saturating), which raises the page-done flag. A byte-acquired flag
// is sampled on specific rotation phases.
//
// Parameters:
//   CH        number of independent channels (1..4)
//   BITS      bits per byte (2..32)
//   MAXBYTES  bytes per page (1..1024)
//
// Ports:
//   i_MCLK    master clock, rising edge
//   i_MRST_n  asynchronous active-low reset
//   bus       mdl_bytecntr_nch_if.slave, control inputs / status outputs
//
// Optional feature macro: BYTECNTR_OVFDET_EN
//   When defined, adds sticky per-channel o_OVF, set when a byte completes
//   while the byte count is already at MAXBYTES.
// -----------------------------------------------------------------------------
module mdl_bytecntr_nch #(
  parameter int CH       = 2,
  parameter int BITS     = 8,
  parameter int MAXBYTES = 64
) (
  input  logic            i_MCLK,
  input  logic            i_MRST_n,
  mdl_bytecntr_nch_if.slave bus
);

  localparam int CW = $clog2(BITS);
  localparam int BW = $clog2(MAXBYTES + 1);

  localparam logic [CW-1:0] BIT_TOP  = CW'(BITS - 1);
  localparam logic [BW-1:0] BYTE_MAX = BW'(MAXBYTES);

  // Shared controls
  logic          ce;
  logic          strobe;
  logic [CH-1:0] done_vec;
  logic [CH-1:0] page_vec;
`ifdef BYTECNTR_OVFDET_EN
  logic [CH-1:0] ovf_vec;
`endif

  assign ce = ~bus.i_CLK2M_PCEN_n;

  // Sample phases 3 and 8 always; 13 and 18 only in 4-bubble mode.
  assign strobe = ~bus.i_ROT20_n[3] | ~bus.i_ROT20_n[8] |
                  (~bus.i_4BEN_n & (~bus.i_ROT20_n[13] | ~bus.i_ROT20_n[18]));

  // Remaining rotation phases carry no meaning for this block.
  logic rot_unused;
  assign rot_unused = ^{bus.i_ROT20_n[19], bus.i_ROT20_n[17:14],
                        bus.i_ROT20_n[12:9], bus.i_ROT20_n[7:4],
                        bus.i_ROT20_n[2:0]};

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic [CW-1:0] bitcnt_reg;
      logic [BW-1:0] bytecnt_reg;
      logic          done_reg;
      logic          clr_bit;
      logic          clr_byte;
      logic          rd;
      logic          wrap;
      logic          bit_zero;
      logic          at_max;

      assign rd       = bus.i_GLCNT_RD[gi];
      assign clr_bit  = bus.i_NEWBYTE | bus.i_ACC_ACT_n | ~bus.i_CH_EN[gi];
      assign clr_byte = bus.i_ACC_ACT_n | ~bus.i_CH_EN[gi];
      assign bit_zero = (bitcnt_reg == '0);
      assign at_max   = (bytecnt_reg == BYTE_MAX);

      // A read at zero completes a byte. A reload in the same cycle wins,
      // so that byte is discarded rather than counted.
      assign wrap = ~clr_bit & rd & bit_zero;

      // Bit counter: counts down the bits still to be read in this byte.
      always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
          bitcnt_reg <= BIT_TOP;
        end else if (ce) begin
          if (clr_bit) begin
            bitcnt_reg <= BIT_TOP;
          end else if (rd) begin
            bitcnt_reg <= bit_zero ? BIT_TOP : (bitcnt_reg - CW'(1));
          end
        end
      end

      // Byte counter: saturates at MAXBYTES; NEWBYTE does not touch it.
      always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
          bytecnt_reg <= '0;
        end else if (ce) begin
          if (clr_byte) begin
            bytecnt_reg <= '0;
          end else if (wrap && !at_max) begin
            bytecnt_reg <= bytecnt_reg + BW'(1);
          end
        end
      end

      // Byte-acquired flag: loaded only on a sample phase. A disabled
      // channel returns to its reset value (0) even between samples.
      always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
          done_reg <= 1'b0;
        end else if (ce) begin
          if (!bus.i_CH_EN[gi]) begin
            done_reg <= 1'b0;
          end else if (strobe) begin
            done_reg <= bit_zero | bus.i_BUBWR_WAIT;
          end
        end
      end

      assign done_vec[gi] = done_reg;
      assign page_vec[gi] = at_max;

`ifdef BYTECNTR_OVFDET_EN
      logic ovf_reg;

      // Sticky: a byte completed with no room left in the page.
      always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
          ovf_reg <= 1'b0;
        end else if (ce) begin
          if (clr_byte) begin
            ovf_reg <= 1'b0;
          end else if (wrap && at_max) begin
            ovf_reg <= 1'b1;
          end
        end
      end

      assign ovf_vec[gi] = ovf_reg;
`endif
    end
  endgenerate

  assign bus.o_BYTEACQ_DONE = done_vec;
  assign bus.o_PAGE_DONE    = page_vec;

  // Disabled channels do not block completion, but with nothing enabled
  // there is nothing to be complete.
  assign bus.o_ALL_DONE = (&(page_vec | ~bus.i_CH_EN)) & (|bus.i_CH_EN);

`ifdef BYTECNTR_OVFDET_EN
  assign bus.o_OVF = ovf_vec;
`endif

endmodule

// File: tb/tb_mdl_bytecntr_nch.sv
// -----------------------------------------------------------------------------
// tb_mdl_bytecntr_nch
// Bench for mdl_bytecntr_nch with CH=2, BITS=8, MAXBYTES=3.
// Directed vector table, hand-written corner sequences, then random stimulus
// compared every clock against a reference model that tracks reads since the
// last bit reload and completed bytes as plain integers.
// -----------------------------------------------------------------------------
module tb_mdl_bytecntr_nch;

  localparam int CH       = 2;
  localparam int BITS     = 8;
  localparam int MAXBYTES = 3;

  logic clk;
  logic rst_n;

  mdl_bytecntr_nch_if #(.CH(CH)) bus ();

  mdl_bytecntr_nch #(
    .CH(CH),
    .BITS(BITS),
    .MAXBYTES(MAXBYTES)
  ) dut (
    .i_MCLK(clk),
    .i_MRST_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_pos[CH];     // reads since the last bit reload
  int m_bytes[CH];   // completed bytes, saturating
  bit m_done[CH];
  bit m_ovf[CH];

  typedef struct {
    logic        pcen_n;
    logic [19:0] rot;
    logic        ben_n;
    logic [1:0]  en;
    logic [1:0]  rd;
    logic        nb;
    logic        acc;
    logic        wt;
    logic [1:0]  e_done;
    logic [1:0]  e_page;
    logic        e_all;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic pcen_n, int rot_idx, logic ben_n,
                              logic [1:0] en, logic [1:0] rd, logic nb,
                              logic acc, logic wt, logic [1:0] e_done,
                              logic [1:0] e_page, logic e_all);
    vec_t v;
    v.pcen_n = pcen_n;
    v.rot    = '1;
    if (rot_idx >= 0) v.rot[rot_idx] = 1'b0;
    v.ben_n  = ben_n;
    v.en     = en;
    v.rd     = rd;
    v.nb     = nb;
    v.acc    = acc;
    v.wt     = wt;
    v.e_done = e_done;
    v.e_page = e_page;
    v.e_all  = e_all;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_pos[c] = 0; m_bytes[c] = 0; m_done[c] = 0; m_ovf[c] = 0;
    end
  endtask

  function automatic logic [1:0] exp_page();
    logic [1:0] p;
    for (int c = 0; c < CH; c++) p[c] = (m_bytes[c] == MAXBYTES);
    return p;
  endfunction

  function automatic logic exp_all();
    logic [1:0] p;
    p = exp_page();
    return (&(p | ~bus.i_CH_EN)) && (bus.i_CH_EN != 0);
  endfunction

  task automatic model_step();
    bit strobe, clr, clrb, rd, wrap;
    int rem;
    strobe = !bus.i_ROT20_n[3] || !bus.i_ROT20_n[8] ||
             (!bus.i_4BEN_n && (!bus.i_ROT20_n[13] || !bus.i_ROT20_n[18]));
    if (bus.i_CLK2M_PCEN_n) return;
    for (int c = 0; c < CH; c++) begin
      clrb = bus.i_ACC_ACT_n || !bus.i_CH_EN[c];
      clr  = bus.i_NEWBYTE || clrb;
      rd   = bus.i_GLCNT_RD[c];
      rem  = (BITS - 1) - (m_pos[c] % BITS);
      wrap = !clr && rd && (rem == 0);
      if (!bus.i_CH_EN[c]) m_done[c] = 0;
      else if (strobe) m_done[c] = (rem == 0) || bus.i_BUBWR_WAIT;
      if (clr) m_pos[c] = 0;
      else if (rd) m_pos[c]++;
      if (clrb) begin
        m_bytes[c] = 0; m_ovf[c] = 0;
      end else if (wrap) begin
        if (m_bytes[c] == MAXBYTES) m_ovf[c] = 1;
        else m_bytes[c]++;
      end
    end
  endtask

  task automatic check_model();
    logic [1:0] d, o;
    for (int c = 0; c < CH; c++) begin
      d[c] = m_done[c];
      o[c] = m_ovf[c];
    end
    check("model_done", 32'(bus.o_BYTEACQ_DONE), 32'(d));
    check("model_page", 32'(bus.o_PAGE_DONE), 32'(exp_page()));
    check("model_all", 32'(bus.o_ALL_DONE), 32'(exp_all()));
`ifdef BYTECNTR_OVFDET_EN
    check("model_ovf", 32'(bus.o_OVF), 32'(o));
`else
    if (o === 2'bxx) $display("unreachable");
`endif
  endtask

  // One clock: model advances on the same edge, outputs sampled 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    bus.i_CLK2M_PCEN_n = 1'b0;
    bus.i_ROT20_n      = '1;
    bus.i_4BEN_n       = 1'b1;
    bus.i_CH_EN        = 2'b11;
    bus.i_GLCNT_RD     = 2'b00;
    bus.i_NEWBYTE      = 1'b0;
    bus.i_ACC_ACT_n    = 1'b0;
    bus.i_BUBWR_WAIT   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", 32'(bus.o_BYTEACQ_DONE), 32'd0);
    check("rst_page", 32'(bus.o_PAGE_DONE), 32'd0);
    check("rst_all", 32'(bus.o_ALL_DONE), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic reads(input logic [1:0] mask, input int n);
    bus.i_GLCNT_RD = mask;
    repeat (n) cycle();
    bus.i_GLCNT_RD = 2'b00;
  endtask

  task automatic sample(input int phase, input logic wt);
    bus.i_ROT20_n = '1;
    bus.i_ROT20_n[phase] = 1'b0;
    bus.i_BUBWR_WAIT = wt;
    cycle();
    bus.i_ROT20_n = '1;
    bus.i_BUBWR_WAIT = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();

    // ---------------- directed vector table ----------------
    tbl.push_back(mk(0, -1, 1, 2'b11, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(0, -1, 1, 2'b11, 2'b01, 0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(0,  3, 1, 2'b11, 2'b00, 0, 0, 0, 2'b01, 2'b00, 0));
    tbl.push_back(mk(0, -1, 1, 2'b11, 2'b00, 0, 0, 0, 2'b01, 2'b00, 0));
    tbl.push_back(mk(0, -1, 1, 2'b11, 2'b00, 1, 0, 0, 2'b01, 2'b00, 0));
    tbl.push_back(mk(0,  8, 1, 2'b11, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(0, -1, 1, 2'b11, 2'b01, 0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 13, 1, 2'b11, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 13, 0, 2'b11, 2'b00, 0, 0, 0, 2'b01, 2'b00, 0));
    tbl.push_back(mk(0, -1, 1, 2'b11, 2'b00, 1, 0, 0, 2'b01, 2'b00, 0));
    tbl.push_back(mk(0,  3, 1, 2'b11, 2'b00, 0, 0, 1, 2'b11, 2'b00, 0));
    tbl.push_back(mk(0,  3, 1, 2'b01, 2'b00, 0, 0, 1, 2'b01, 2'b00, 0));
    tbl.push_back(mk(0, -1, 1, 2'b11, 2'b00, 0, 0, 0, 2'b01, 2'b00, 0));
    tbl.push_back(mk(1,  3, 1, 2'b11, 2'b00, 0, 0, 1, 2'b01, 2'b00, 0));
    tbl.push_back(mk(0, 18, 0, 2'b11, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      bus.i_CLK2M_PCEN_n = tbl[i].pcen_n;
      bus.i_ROT20_n      = tbl[i].rot;
      bus.i_4BEN_n       = tbl[i].ben_n;
      bus.i_CH_EN        = tbl[i].en;
      bus.i_GLCNT_RD     = tbl[i].rd;
      bus.i_NEWBYTE      = tbl[i].nb;
      bus.i_ACC_ACT_n    = tbl[i].acc;
      bus.i_BUBWR_WAIT   = tbl[i].wt;
      cycle();
      check($sformatf("tbl%0d_done", i), 32'(bus.o_BYTEACQ_DONE), 32'(tbl[i].e_done));
      check($sformatf("tbl%0d_page", i), 32'(bus.o_PAGE_DONE), 32'(tbl[i].e_page));
      check($sformatf("tbl%0d_all", i), 32'(bus.o_ALL_DONE), 32'(tbl[i].e_all));
      $display("vec %0d: done=%b page=%b all=%b", i, bus.o_BYTEACQ_DONE,
               bus.o_PAGE_DONE, bus.o_ALL_DONE);
    end

    // ---------------- page completion and ALL_DONE ----------------
    do_reset();
    bus.i_NEWBYTE = 1'b1; cycle(); bus.i_NEWBYTE = 1'b0;
    reads(2'b10, 23);
    check("page_before_24", 32'(bus.o_PAGE_DONE), 32'd0);
    reads(2'b10, 1);
    check("page_at_24", 32'(bus.o_PAGE_DONE), 32'b10);
    bus.i_CH_EN = 2'b10; #1;
    check("all_en10", 32'(bus.o_ALL_DONE), 32'd1);
    bus.i_CH_EN = 2'b11; #1;
    check("all_en11", 32'(bus.o_ALL_DONE), 32'd0);
    bus.i_CH_EN = 2'b00; #1;
    check("all_en00", 32'(bus.o_ALL_DONE), 32'd0);
    bus.i_CH_EN = 2'b11;
    $display("seq page: page=%b", bus.o_PAGE_DONE);

    // ---------------- reload dominates a read at zero ----------------
    reads(2'b01, 7);
    bus.i_NEWBYTE = 1'b1; bus.i_GLCNT_RD = 2'b01;
    cycle();
    bus.i_NEWBYTE = 1'b0; bus.i_GLCNT_RD = 2'b00;
    sample(3, 1'b0);
    check("nb_rd_bitcnt_reloaded", 32'(bus.o_BYTEACQ_DONE[0]), 32'd0);
    reads(2'b01, 16);
    check("nb_rd_no_byte", 32'(bus.o_PAGE_DONE[0]), 32'd0);
    reads(2'b01, 8);
    check("nb_rd_page_later", 32'(bus.o_PAGE_DONE[0]), 32'd1);
    $display("seq newbyte+read: page=%b", bus.o_PAGE_DONE);

    // ---------------- saturation / overflow ----------------
    reads(2'b01, 8);
    check("sat_page", 32'(bus.o_PAGE_DONE[0]), 32'd1);
`ifdef BYTECNTR_OVFDET_EN
    check("ovf_set", 32'(bus.o_OVF[0]), 32'd1);
`endif
    bus.i_ACC_ACT_n = 1'b1; cycle(); bus.i_ACC_ACT_n = 1'b0;
    check("acc_clr_page", 32'(bus.o_PAGE_DONE), 32'd0);
`ifdef BYTECNTR_OVFDET_EN
    check("acc_clr_ovf", 32'(bus.o_OVF), 32'd0);
`endif
    $display("seq saturate: page=%b", bus.o_PAGE_DONE);

    // ---------------- asynchronous reset mid-byte ----------------
    reads(2'b10, 24);
    reads(2'b01, 3);
    sample(3, 1'b1);
    check("pre_rst_done", 32'(bus.o_BYTEACQ_DONE), 32'b11);
    check("pre_rst_page", 32'(bus.o_PAGE_DONE), 32'b10);
    bus.i_CLK2M_PCEN_n = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_done", 32'(bus.o_BYTEACQ_DONE), 32'd0);
    check("async_rst_page", 32'(bus.o_PAGE_DONE), 32'd0);
    check("async_rst_all", 32'(bus.o_ALL_DONE), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_CLK2M_PCEN_n = 1'b0;
    sample(3, 1'b0);
    check("post_rst_bitcnt_top", 32'(bus.o_BYTEACQ_DONE), 32'd0);
    $display("seq async reset: done=%b page=%b", bus.o_BYTEACQ_DONE,
             bus.o_PAGE_DONE);

    // ---------------- randomized against the model ----------------
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int ph;
      bus.i_CLK2M_PCEN_n = ($urandom_range(0, 3) == 0);
      bus.i_ROT20_n      = '1;
      ph = $urandom_range(0, 29);
      if (ph < 20) bus.i_ROT20_n[ph] = 1'b0;
      bus.i_4BEN_n       = 1'($urandom_range(0, 1));
      bus.i_GLCNT_RD     = 2'($urandom_range(0, 3));
      bus.i_NEWBYTE      = ($urandom_range(0, 15) == 0);
      bus.i_ACC_ACT_n    = ($urandom_range(0, 63) == 0);
      bus.i_BUBWR_WAIT   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 49) == 0) bus.i_CH_EN = 2'($urandom_range(0, 3));
      else if ($urandom_range(0, 19) == 0) bus.i_CH_EN = 2'b11;
      cycle();
      if (i % 300 == 0)
        $display("rand %0d: done=%b page=%b all=%b", i, bus.o_BYTEACQ_DONE,
                 bus.o_PAGE_DONE, bus.o_ALL_DONE);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdl_bytecntr_nch.md
MDL_BYTECNTR_NCH -- requirements
Module: mdl_bytecntr_nch

Interface
REQ-001 SHALL provide parameter CH, default 2, meaning number of independent bubble channels (1..4).
REQ-002 SHALL provide parameter BITS, default 8, meaning bits per byte (2..32); bit counter width CW = clog2(BITS).
REQ-003 SHALL provide parameter MAXBYTES, default 64, meaning bytes per page (1..1024); byte counter width BW = clog2(MAXBYTES+1).
REQ-004 i_MCLK  in  1  master clock; all state changes on its rising edge; one clock, no other clock.
REQ-005 i_MRST_n  in  1  asynchronous active-low reset.
REQ-006 i_CLK2M_PCEN_n  in  1  active-low clock enable; all registers hold when high.
REQ-007 i_ROT20_n  in  20  active-low one-hot rotation phase timing.
REQ-008 i_4BEN_n  in  1  active-low 4-bubble mode; adds sample phases 13 and 18.
REQ-009 i_CH_EN  in  CH  per-channel enable.
REQ-010 i_GLCNT_RD  in  CH  per-channel bit-read strobe.
REQ-011 i_NEWBYTE  in  1  bit-counter reload for all channels.
REQ-012 i_ACC_ACT_n  in  1  access inactive (high) = full clear of bit and byte counters.
REQ-013 i_BUBWR_WAIT  in  1  forces DONE high at the next sample.
REQ-014 o_BYTEACQ_DONE  out  CH  per-channel byte-acquired flag, registered.
REQ-015 o_PAGE_DONE  out  CH  per-channel byte count == MAXBYTES.
REQ-016 o_ALL_DONE  out  1  every enabled channel PAGE_DONE, and at least one channel enabled.

Function
REQ-017 Updates SHALL occur only on i_MCLK edges where i_CLK2M_PCEN_n = 0.
REQ-018 Bit counter: clr = i_NEWBYTE | i_ACC_ACT_n | ~i_CH_EN[c]. clr reloads BITS-1; else on i_GLCNT_RD[c], 0 reloads BITS-1 and emits wrap[c], nonzero decrements; else hold.
REQ-019 clr SHALL dominate a simultaneous i_GLCNT_RD[c]; no wrap is emitted that cycle.
REQ-020 Sample strobe SHALL be ~ROT20_n[3] | ~ROT20_n[8] | (~i_4BEN_n & (~ROT20_n[13] | ~ROT20_n[18])).
REQ-021 On a strobe, o_BYTEACQ_DONE[c] SHALL load (bitcnt[c]==0 | i_BUBWR_WAIT) & i_CH_EN[c]; otherwise it holds. Latency is 1 enabled clock from the strobe.
REQ-022 Byte counter SHALL clear to 0 on i_ACC_ACT_n or ~i_CH_EN[c]. It SHALL increment on wrap[c]. It saturates at MAXBYTES; a wrap at MAXBYTES holds the count. i_NEWBYTE SHALL NOT affect it.
REQ-023 o_PAGE_DONE[c] SHALL be registered byte count == MAXBYTES, decoded combinationally from the register.
REQ-024 o_ALL_DONE SHALL equal &(o_PAGE_DONE | ~i_CH_EN) & |i_CH_EN; it is 0 when no channel is enabled.
REQ-025 Channels SHALL be fully independent; no cross-channel state.
REQ-026 Deasserting i_CH_EN[c] mid-byte SHALL return channel c to reset values on the next enabled clock.

Reset
REQ-027 While i_MRST_n = 0, asynchronously: bit counters = BITS-1, byte counters = 0, o_BYTEACQ_DONE = 0, o_PAGE_DONE = 0, o_OVF = 0 when present.
REQ-028 Reset release SHALL take effect on the first enabled clock; reset mid-operation discards all progress.

Configuration
REQ-029 Macro BYTECNTR_OVFDET_EN: when defined, the block SHALL add output o_OVF (CH, sticky) that sets on wrap[c] while the byte count is already MAXBYTES. o_OVF SHALL clear only on reset, i_ACC_ACT_n, or ~i_CH_EN[c].
REQ-030 When BYTECNTR_OVFDET_EN is undefined, o_OVF SHALL be absent and the saturating behaviour is unchanged.

Verification
REQ-031 CH=2, BITS=8: NEWBYTE pulse, then 7 GLCNT_RD[0] -> bitcnt[0]=0; ROT20_n[3] low -> DONE[0]=1 next enabled clock, DONE[1]=0.
REQ-032 i_4BEN_n=1 with counter 0 and only ROT20_n[13] low -> DONE holds. Same stimulus with i_4BEN_n=0 -> DONE=1.
REQ-033 MAXBYTES=3: 24 reads on ch1 -> PAGE_DONE[1]=1. With CH_EN=2'b10 -> ALL_DONE=1. With CH_EN=2'b11 -> ALL_DONE=0.
REQ-034 NEWBYTE and GLCNT_RD asserted together at bitcnt=0 -> bitcnt=7, byte count unchanged.
REQ-035 BYTECNTR_OVFDET_EN, MAXBYTES=3: 32 reads -> count stays 3, o_OVF[0]=1. ACC_ACT_n high -> count 0, o_OVF=0.
REQ-036 i_MRST_n pulsed low mid-byte with PCEN idle -> outputs 0 and bitcnt=7 immediately, without a clock.
